// File: rtl/pipelined_barrel_shifter.sv
// Streaming multi-mode barrel shifter: one registered shift level per stage,
// with valid/ready flow control and full backpressure (no skid buffer).
module pipelined_barrel_shifter #(
  parameter  int N      = 8,
  localparam int LEVELS = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      data_i,
  input  logic [LEVELS-1:0] shift_amount_i,
  input  logic              shift_direction_i,
  input  logic [1:0]        mode_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [N-1:0]      shifted_data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  // One shift level: distance 2**lvl when do_sh is set. Arithmetic left and
  // the reserved mode fall through to the logical path.
  function automatic logic [N-1:0] shift_level(
    input logic [N-1:0] d,
    input int           lvl,
    input logic         do_sh,
    input logic         dir,
    input logic [1:0]   mode,
    input logic         sgn
  );
    logic [2*N-1:0] w;
    logic [N-1:0]   fill;
    logic [N-1:0]   r;
    w    = '0;
    fill = (mode == MODE_ARITH && sgn) ? '1 : '0;
    if (!do_sh) begin
      r = d;
    end else if (mode == MODE_ROT) begin
      if (dir) begin
        w = {d, d} >> (2**lvl);
        r = w[N-1:0];
      end else begin
        w = {d, d} << (2**lvl);
        r = w[2*N-1:N];
      end
    end else if (dir) begin
      w = {fill, d} >> (2**lvl);
      r = w[N-1:0];
    end else begin
      r = d << (2**lvl);
    end
    return r;
  endfunction

  // Per-stage state; index k is the register at the output of level k.
  logic [N-1:0]      data_q [LEVELS];
  logic [N-1:0]      data_d [LEVELS];
  logic [LEVELS-1:0] amt_q  [LEVELS];
  logic [LEVELS-1:0] amt_d  [LEVELS];
  logic [1:0]        mode_q [LEVELS];
  logic [1:0]        mode_d [LEVELS];
  logic              dir_q  [LEVELS];
  logic              dir_d  [LEVELS];
  logic              sgn_q  [LEVELS];
  logic              sgn_d  [LEVELS];
  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] vld_d;
  logic [LEVELS-1:0] en;

  // Values presented to each level: the inputs for level 0, the previous
  // stage register otherwise.
  logic [N-1:0]      in_data [LEVELS];
  logic [LEVELS-1:0] in_amt  [LEVELS];
  logic [1:0]        in_mode [LEVELS];
  logic              in_dir  [LEVELS];
  logic              in_sgn  [LEVELS];
  logic              in_vld  [LEVELS];

  // Stage enables: a stage may load when it is empty or everything downstream
  // of it moves. Accumulated from the output end to avoid a chained loop.
  always_comb begin
    logic acc;
    acc = ready_i;
    en  = '0;
    for (int k = LEVELS - 1; k >= 0; k--) begin
      acc   = acc || !vld_q[k];
      en[k] = acc;
    end
  end

  // Nothing is accepted while reset is asserted.
  assign ready_o = en[0] && rst_n;

  // Route each level's source: external inputs for level 0, previous stage otherwise.
  always_comb begin
    in_data[0] = data_i;
    in_amt[0]  = shift_amount_i;
    in_mode[0] = mode_i;
    in_dir[0]  = shift_direction_i;
    in_sgn[0]  = data_i[N-1];
    in_vld[0]  = valid_i && ready_o;
    for (int k = 1; k < LEVELS; k++) begin
      in_data[k] = data_q[k-1];
      in_amt[k]  = amt_q[k-1];
      in_mode[k] = mode_q[k-1];
      in_dir[k]  = dir_q[k-1];
      in_sgn[k]  = sgn_q[k-1];
      in_vld[k]  = vld_q[k-1];
    end
  end

  // Next-state per stage: enabled stages load the shifted source, others hold.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < LEVELS; k++) begin
      data_d[k] = data_q[k];
      amt_d[k]  = amt_q[k];
      mode_d[k] = mode_q[k];
      dir_d[k]  = dir_q[k];
      sgn_d[k]  = sgn_q[k];
      if (en[k]) begin
        data_d[k] = shift_level(in_data[k], k, in_amt[k][k], in_dir[k],
                                in_mode[k], in_sgn[k]);
        amt_d[k]  = in_amt[k];
        mode_d[k] = in_mode[k];
        dir_d[k]  = in_dir[k];
        sgn_d[k]  = in_sgn[k];
        vld_d[k]  = in_vld[k];
      end
    end
  end

  // Stage registers; reset clears every valid and zeroes the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
        dir_q[k]  <= 1'b0;
        sgn_q[k]  <= 1'b0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
        mode_q[k] <= mode_d[k];
        dir_q[k]  <= dir_d[k];
        sgn_q[k]  <= sgn_d[k];
      end
    end
  end

  assign shifted_data_o = data_q[LEVELS-1];
  assign valid_o        = vld_q[LEVELS-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=8): directed cases,
// a back-to-back sweep, backpressure, mid-stream reset and random traffic.
module tb_pipelined_barrel_shifter;

  localparam int N  = 8;
  localparam int LV = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic [2:0] shift_amount_i;
  logic       shift_direction_i;
  logic [1:0] mode_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] shifted_data_o;
  logic       valid_o;
  logic       ready_i;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .data_i            (data_i),
    .shift_amount_i    (shift_amount_i),
    .shift_direction_i (shift_direction_i),
    .mode_i            (mode_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .shifted_data_o    (shifted_data_o),
    .valid_o           (valid_o),
    .ready_i           (ready_i)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  int         cycle_cnt = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic       prev_vo   = 1'b0;
  logic       prev_ri   = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       chk_lat   = 1'b0;
  logic       acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word shift computed with integer arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a,
                                           input logic dir, input logic [1:0] m);
    int x;
    int s;
    int r;
    x = int'(d);
    if (m == 2'b10)
      r = dir ? ((x >> a) | (x << (N - a))) : ((x << a) | (x >> (N - a)));
    else if (m == 2'b01 && dir) begin
      s = d[7] ? x - 256 : x;
      r = s >>> a;
    end else
      r = dir ? (x >> a) : (x << a);
    return 8'(r & 255);
  endfunction

  // One clock: drive, sample before the edge, score transfers, advance.
  task automatic cyc(input logic rst_a, input logic vi, input logic [7:0] d,
                     input logic [2:0] a, input logic dr, input logic [1:0] m,
                     input logic ri, input logic ovr, input logic [7:0] ovr_v,
                     output logic accepted);
    logic [7:0] e;
    int         t;
    rst_n = !rst_a; valid_i = vi; data_i = d; shift_amount_i = a;
    shift_direction_i = dr; mode_i = m; ready_i = ri;
    #1;
    if (prev_vo && !prev_ri && !rst_a) begin
      check("hold_valid", 32'(valid_o), 32'(1));
      check("hold_data", 32'(shifted_data_o), 32'(prev_data));
    end
    if (valid_o && ri && !rst_a) begin
      if (exp_q.size() == 0)
        check("stale_word", 32'(valid_o), 32'(0));
      else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check("out_data", 32'(shifted_data_o), 32'(e));
        if (chk_lat) check("latency", 32'(cycle_cnt - t), 32'(LV));
      end
    end
    accepted = vi && ready_o && !rst_a;
    if (accepted) begin
      exp_q.push_back(ovr ? ovr_v : ref_shift(d, int'(a), dr, m));
      acc_q.push_back(cycle_cnt);
    end
    prev_vo   = valid_o && !rst_a;
    prev_ri   = ri;
    prev_data = shifted_data_o;
    @(posedge clk);
    cycle_cnt++;
    if (rst_a) begin
      exp_q.delete();
      acc_q.delete();
      prev_vo = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic dr,
                      input logic [1:0] m, input logic ovr, input logic [7:0] ov);
    logic x;
    cyc(1'b0, 1'b1, d, a, dr, m, 1'b1, ovr, ov, x);
  endtask

  task automatic idle(input int n);
    logic x;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cycle_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; data_i = 8'h00; shift_amount_i = 3'd0;
    shift_direction_i = 1'b0; mode_i = 2'b00; ready_i = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, acc);
    cyc(1'b1, 1'b1, 8'hAA, 3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, acc);

    // Reset state
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    #1;
    check("reset_valid", 32'(valid_o), 32'(0));
    check("reset_data", 32'(shifted_data_o), 32'(0));
    check("reset_ready", 32'(ready_o), 32'(1));

    // Directed cases, back to back with fixed latency
    chk_lat = 1'b1;
    send(8'hF0, 3'd4, 1'b1, 2'b00, 1'b1, 8'h0F);
    send(8'hF0, 3'd2, 1'b1, 2'b01, 1'b1, 8'hFC);
    send(8'h70, 3'd2, 1'b1, 2'b01, 1'b1, 8'h1C);
    send(8'h96, 3'd3, 1'b0, 2'b10, 1'b1, 8'hB4);
    send(8'h96, 3'd3, 1'b1, 2'b10, 1'b1, 8'hD2);
    send(8'hF0, 3'd1, 1'b1, 2'b11, 1'b1, 8'h78);
    send(8'hF0, 3'd3, 1'b0, 2'b01, 1'b1, 8'h80);
    idle(5);

    // Full sweep, one word per cycle; amount 0 must return the input
    for (int m = 0; m < 3; m++)
      for (int dr = 0; dr < 2; dr++)
        for (int a = 0; a < 8; a++)
          send(8'hF0, 3'(a), 1'(dr), 2'(m), (a == 0), 8'hF0);
    idle(5);
    chk_lat = 1'b0;

    // Backpressure: three fill the pipe, the fourth waits for the drain edge
    cyc(1'b0, 1'b1, 8'hA5, 3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, acc);
    check("bp_acc1", 32'(acc), 32'(1));
    cyc(1'b0, 1'b1, 8'hC3, 3'd2, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, acc);
    check("bp_acc2", 32'(acc), 32'(1));
    cyc(1'b0, 1'b1, 8'h3C, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0, 8'h00, acc);
    check("bp_acc3", 32'(acc), 32'(1));
    cyc(1'b0, 1'b1, 8'h81, 3'd5, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, acc);
    check("bp_full_block", 32'(acc), 32'(0));
    cyc(1'b0, 1'b1, 8'h81, 3'd5, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, acc);
    check("bp_full_block2", 32'(acc), 32'(0));
    cyc(1'b0, 1'b1, 8'h81, 3'd5, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, acc);
    check("bp_accept_on_drain", 32'(acc), 32'(1));
    idle(3);
    check("bp_drain_done", 32'(exp_q.size()), 32'(0));
    idle(2);

    // Reset with two words in flight
    chk_lat = 1'b1;
    send(8'h5A, 3'd1, 1'b0, 2'b00, 1'b0, 8'h00);
    send(8'hE1, 3'd2, 1'b1, 2'b10, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hFF, 3'd1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, acc);
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    #1;
    check("rst_mid_valid", 32'(valid_o), 32'(0));
    check("rst_mid_data", 32'(shifted_data_o), 32'(0));
    idle(3);
    send(8'h81, 3'd3, 1'b1, 2'b01, 1'b1, 8'hF0);
    idle(5);
    chk_lat = 1'b0;

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++)
      cyc(1'b0, ($urandom % 4) != 0, 8'($urandom), 3'($urandom), 1'($urandom),
          2'($urandom), ($urandom % 4) != 0, 1'b0, 8'h00, acc);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("final_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
